// File: rtl/instruction_line_unpacker.sv
// Fetch-side unpacker: buffers wide instruction-memory lines in a small FIFO
// and emits one decoded instruction per cycle with its PC and class flags.
module instruction_line_unpacker #(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int TYPE_WIDTH        = 3,
  parameter int LINE_INSTRS       = 4,
  parameter int PC_WIDTH          = 9,
  parameter int DEPTH             = 2,
  parameter int STOP_AT_FLOW      = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    line_valid,
  output logic                                    line_ready,
  input  logic [LINE_INSTRS*INSTRUCTION_WIDTH-1:0] line_data,
  input  logic [PC_WIDTH-1:0]                     line_pc,
  input  logic                                    flush,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [PC_WIDTH-1:0]                     out_pc,
  output logic [TYPE_WIDTH-1:0]                   out_type,
  output logic [INSTRUCTION_WIDTH-TYPE_WIDTH-1:0] out_data,
  output logic                                    out_is_branch,
  output logic                                    out_is_terminal,
  output logic                                    out_illegal
);

  localparam int SW = $clog2(LINE_INSTRS);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = INSTRUCTION_WIDTH - TYPE_WIDTH;
  localparam int LW = LINE_INSTRS * INSTRUCTION_WIDTH;
  localparam int BW = PC_WIDTH - SW;

  logic [LW-1:0]            mem_data_r  [DEPTH];
  logic [BW-1:0]            mem_base_r  [DEPTH];
  logic [SW-1:0]            mem_start_r [DEPTH];
  logic [PW-1:0]            wr_ptr_r;
  logic [PW-1:0]            rd_ptr_r;
  logic [PW:0]              count_r;
  logic [SW-1:0]            slot_r;

  logic                     valid_s;
  logic                     push_s;
  logic                     hs_s;
  logic                     pop_s;
  logic                     last_slot_s;
  logic                     flow_stop_s;
  logic [PW-1:0]            next_rd_s;
  logic [LW-1:0]            head_line_s;
  logic [INSTRUCTION_WIDTH-1:0] head_instr_s;
  logic [TYPE_WIDTH-1:0]    type_s;
  logic                     is_jmp_s;
  logic                     is_split_s;
  logic                     is_term_s;
  logic                     is_illegal_s;

  assign valid_s     = (count_r != {(PW+1){1'b0}});
  assign line_ready  = (count_r < (PW+1)'(DEPTH)) && !flush && !rst;
  assign push_s      = line_valid && line_ready;
  assign hs_s        = valid_s && out_ready && !flush;
  assign last_slot_s = (slot_r == SW'(LINE_INSTRS - 1));
  assign next_rd_s   = rd_ptr_r + PW'(1);
  assign head_line_s = mem_data_r[rd_ptr_r];

  // Select the current slot of the head line and classify its opcode.
  always_comb begin
    head_instr_s = head_line_s[int'(slot_r)*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
    type_s       = head_instr_s[INSTRUCTION_WIDTH-1 -: TYPE_WIDTH];
    is_split_s   = (type_s == TYPE_WIDTH'(1));
    is_jmp_s     = (type_s == TYPE_WIDTH'(3));
    is_term_s    = (type_s == TYPE_WIDTH'(0)) || (type_s == TYPE_WIDTH'(4)) ||
                   (type_s == TYPE_WIDTH'(6));
    is_illegal_s = (type_s > TYPE_WIDTH'(7));
  end

  // SPLIT falls through to the next slot, so only JMP and terminals cut a line short.
  assign flow_stop_s = (STOP_AT_FLOW != 0) && (is_jmp_s || is_term_s);
  assign pop_s       = hs_s && (last_slot_s || flow_stop_s);

  // Decoded output view of the head slot, forced to zero while empty.
  always_comb begin
    out_valid       = valid_s;
    out_pc          = {PC_WIDTH{1'b0}};
    out_type        = {TYPE_WIDTH{1'b0}};
    out_data        = {OW{1'b0}};
    out_is_branch   = 1'b0;
    out_is_terminal = 1'b0;
    out_illegal     = 1'b0;
    if (valid_s) begin
      out_pc          = {mem_base_r[rd_ptr_r], slot_r};
      out_type        = type_s;
      out_data        = head_instr_s[OW-1:0];
      out_is_branch   = is_split_s || is_jmp_s;
      out_is_terminal = is_term_s;
      out_illegal     = is_illegal_s;
    end else begin
      out_pc          = {PC_WIDTH{1'b0}};
    end
  end

  // Line storage; contents are only observed through occupied entries.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_data_r[wr_ptr_r]  <= line_data;
      mem_base_r[wr_ptr_r]  <= line_pc[PC_WIDTH-1:SW];
      mem_start_r[wr_ptr_r] <= line_pc[SW-1:0];
    end
  end

  // Pointers, occupancy and head slot counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
      slot_r   <= {SW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
      slot_r   <= {SW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= next_rd_s;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
      // A line pushed while the last buffered one pops is not in storage yet.
      if (pop_s) begin
        if (count_r == (PW+1)'(1)) slot_r <= push_s ? line_pc[SW-1:0] : {SW{1'b0}};
        else                        slot_r <= mem_start_r[next_rd_s];
      end else if (hs_s) begin
        slot_r <= slot_r + SW'(1);
      end else if (push_s && !valid_s) begin
        slot_r <= line_pc[SW-1:0];
      end else begin
        slot_r <= slot_r;
      end
    end
  end

endmodule

// File: tb/tb_instruction_line_unpacker.sv
// Randomized bench for instruction_line_unpacker: two configurations checked
// against a line-expansion reference model plus directed corner cases.
module tb_instruction_line_unpacker;

  logic        clk = 1'b0;
  logic        rst, line_valid, flush, out_ready, sel;
  logic [63:0] line_data;
  logic [8:0]  line_pc;

  logic        a_ready, a_valid, a_br, a_term, a_ill;
  logic [8:0]  a_pc;
  logic [2:0]  a_type;
  logic [12:0] a_data;
  logic        b_ready, b_valid, b_br, b_term, b_ill;
  logic [8:0]  b_pc;
  logic [3:0]  b_type;
  logic [11:0] b_data;

  instruction_line_unpacker #(.STOP_AT_FLOW(1)) u_dut_a (
    .clk(clk), .rst(rst), .line_valid(line_valid), .line_ready(a_ready),
    .line_data(line_data), .line_pc(line_pc), .flush(flush),
    .out_valid(a_valid), .out_ready(out_ready), .out_pc(a_pc), .out_type(a_type),
    .out_data(a_data), .out_is_branch(a_br), .out_is_terminal(a_term), .out_illegal(a_ill));

  instruction_line_unpacker #(.TYPE_WIDTH(4), .STOP_AT_FLOW(0)) u_dut_b (
    .clk(clk), .rst(rst), .line_valid(line_valid), .line_ready(b_ready),
    .line_data(line_data), .line_pc(line_pc), .flush(flush),
    .out_valid(b_valid), .out_ready(out_ready), .out_pc(b_pc), .out_type(b_type),
    .out_data(b_data), .out_is_branch(b_br), .out_is_terminal(b_term), .out_illegal(b_ill));

  always #5 clk = ~clk;

  wire        obs_ready = sel ? b_ready : a_ready;
  wire        obs_valid = sel ? b_valid : a_valid;
  wire [8:0]  obs_pc    = sel ? b_pc : a_pc;
  wire [3:0]  obs_type  = sel ? b_type : {1'b0, a_type};
  wire [12:0] obs_data  = sel ? {1'b0, b_data} : a_data;
  wire [2:0]  obs_flags = sel ? {b_br, b_term, b_ill} : {a_br, a_term, a_ill};

  typedef struct packed {
    logic [8:0]  pc;
    logic [3:0]  typ;
    logic [12:0] dat;
    logic        br, term, ill, last;
  } exp_t;

  exp_t q[$];
  int   lines = 0;
  int   emitted = 0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input int typ, input int opnd);
    int tw;
    tw = sel ? 4 : 3;
    return 16'((typ << (16 - tw)) | opnd);
  endfunction

  // Reference: expand an accepted line into the instructions it will emit.
  task automatic model_push(input logic [63:0] d, input logic [8:0] pc);
    int          tw;
    bit          stop;
    logic [15:0] ins;
    exp_t        e;
    tw   = sel ? 4 : 3;
    stop = !sel;
    for (int k = int'(pc[1:0]); k < 4; k++) begin
      ins    = d[k*16 +: 16];
      e.typ  = 4'(ins >> (16 - tw));
      e.dat  = 13'(ins & ((16'd1 << (16 - tw)) - 16'd1));
      e.pc   = {pc[8:2], 2'b00} + 9'(k);
      e.br   = (e.typ == 4'd1) || (e.typ == 4'd3);
      e.term = (e.typ == 4'd0) || (e.typ == 4'd4) || (e.typ == 4'd6);
      e.ill  = (e.typ >= 4'd8);
      e.last = (k == 3) || (stop && ((e.typ == 4'd3) || e.term));
      q.push_back(e);
      if (e.last) break;
    end
    lines++;
  endtask

  task automatic cycle();
    logic exp_ready;
    bit   pushed, popped;
    #4;
    exp_ready = (lines < 2) && !flush && !rst;
    check("line_ready", obs_ready, exp_ready);
    check("out_valid", obs_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_pc", obs_pc, q[0].pc);
      check("out_type", obs_type, q[0].typ);
      check("out_data", obs_data, q[0].dat);
      check("out_flags", obs_flags, {q[0].br, q[0].term, q[0].ill});
    end else begin
      check("idle_out", {obs_pc, obs_type, obs_data, obs_flags}, 32'd0);
    end
    pushed = line_valid && exp_ready;
    popped = (q.size() != 0) && out_ready;
    @(posedge clk);
    if (popped) emitted++;
    if (flush) begin
      q.delete();
      lines = 0;
    end else begin
      if (popped) begin
        if (q[0].last) lines--;
        void'(q.pop_front());
      end
      if (pushed) model_push(line_data, line_pc);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; line_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    q.delete(); lines = 0; emitted = 0;
    rst = 1'b0;
  endtask

  task automatic offer(input logic [63:0] d, input logic [8:0] pc);
    line_data = d; line_pc = pc; line_valid = 1'b1;
    cycle();
    line_valid = 1'b0;
  endtask

  logic [63:0] demo;

  initial begin
    sel = 1'b0; rst = 1'b1; line_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    line_data = 64'd0; line_pc = 9'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_a", a_ready, 1'b0);
    check("rst_ready_b", b_ready, 1'b0);
    check("rst_valid", {a_valid, b_valid}, 2'b00);
    check("rst_out", {a_pc, a_type, a_data, a_br, a_term, a_ill}, 32'd0);

    // Full line, no truncation (JMP flagged as branch, ACCEPT as terminal).
    sel = 1'b1; do_reset();
    demo = {mk(0, 0), mk(3, 0), mk(2, 8'h62), mk(2, 8'h61)};
    out_ready = 1'b1;
    offer(demo, 9'h010);
    repeat (6) cycle();
    check("full_line_count", emitted, 4);

    // Same line truncated after JMP.
    sel = 1'b0; do_reset();
    demo = {mk(0, 0), mk(3, 0), mk(2, 8'h62), mk(2, 8'h61)};
    out_ready = 1'b1;
    offer(demo, 9'h010);
    repeat (5) cycle();
    check("stop_flow_count", emitted, 3);

    // Mid-line start slot.
    emitted = 0;
    offer({mk(2, 4), mk(2, 3), mk(2, 2), mk(2, 1)}, 9'h00E);
    repeat (4) cycle();
    check("start_slot_count", emitted, 2);

    // Fill with consumer stalled, then drain with a line held valid.
    out_ready = 1'b0;
    line_data = {mk(5, 1), mk(7, 2), mk(2, 3), mk(1, 4)}; line_pc = 9'h020; line_valid = 1'b1;
    repeat (5) cycle();
    check("full_not_ready", a_ready, 1'b0);
    out_ready = 1'b1;
    repeat (10) cycle();
    line_valid = 1'b0;
    repeat (12) cycle();

    // Flush with two lines buffered and a third offered.
    out_ready = 1'b0; line_valid = 1'b1;
    repeat (2) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0; line_valid = 1'b0;
    check("flush_valid", a_valid, 1'b0);
    cycle();

    // Illegal opcode, then asynchronous reset mid-line.
    sel = 1'b1; do_reset();
    offer({mk(2, 1), mk(1, 2), mk(4, 3), mk(9, 5)}, 9'h040);
    out_ready = 1'b0;
    repeat (2) cycle();
    check("illegal_flags", {b_br, b_term, b_ill}, 3'b001);
    out_ready = 1'b1;
    cycle();
    rst = 1'b1;
    #1;
    check("async_rst_valid", b_valid, 1'b0);
    check("async_rst_ready", b_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; q.delete(); lines = 0;
    cycle();

    // Randomized traffic on both configurations.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      for (int n = 0; n < 1500; n++) begin
        line_valid = ($urandom % 4) != 0;
        line_data  = {$urandom, $urandom};
        line_pc    = 9'($urandom);
        out_ready  = ($urandom % 3) != 0;
        flush      = ($urandom % 32) == 0;
        cycle();
      end
      flush = 1'b0; line_valid = 1'b0; out_ready = 1'b1;
      repeat (10) cycle();
      check("drained", obs_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_line_unpacker.md
# instruction_line_unpacker

Parametrised fetch-side unpacker for the regex CPU. It accepts wide instruction-memory lines, each holding LINE_INSTRS packed instructions, and buffers them in a small line FIFO. It then emits one decoded instruction per cycle with its PC, type, operand and classification flags. It sits between the instruction memory read port and the CPU execute stage, and supports flush on control-flow redirect plus an optional stop-at-control-flow mode.

## Interface
- INSTRUCTION_WIDTH, 16, bits per instruction.
- TYPE_WIDTH, 3, opcode field width; the opcode occupies the top bits of the instruction.
- LINE_INSTRS, 4, instructions per memory line; must be a power of two, ≥2.
- PC_WIDTH, 9, instruction address width.
- DEPTH, 2, line FIFO entries; must be a power of two, ≥2.
- STOP_AT_FLOW, 1, when 1, discard the remaining slots of a line after a JMP or terminal instruction.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- line_valid  in  1  line offered.
- line_ready  out  1  line accepted when line_valid && line_ready.
- line_data  in  LINE_INSTRS*INSTRUCTION_WIDTH  slot k occupies bits [k*IW +: IW].
- line_pc  in  PC_WIDTH  PC of the first instruction to emit; the low log2(LINE_INSTRS) bits give the start slot.
- flush  in  1  synchronous discard of all buffered state.
- out_valid  out  1  decoded instruction present.
- out_ready  in  1  consumer takes the instruction when out_valid && out_ready.
- out_pc  out  PC_WIDTH  address of the emitted instruction.
- out_type  out  TYPE_WIDTH  opcode field.
- out_data  out  INSTRUCTION_WIDTH-TYPE_WIDTH  operand, taken from the low bits.
- out_is_branch  out  1  type is SPLIT(1) or JMP(3).
- out_is_terminal  out  1  type is ACCEPT(0), END_WITHOUT_ACCEPTING(4) or ACCEPT_PARTIAL(6).
- out_illegal  out  1  opcode ≥ 8; only possible when TYPE_WIDTH > 3.

## Operation
- Opcode encoding is fixed: 0 ACCEPT, 1 SPLIT, 2 MATCH, 3 JMP, 4 END_WITHOUT_ACCEPTING, 5 MATCH_ANY, 6 ACCEPT_PARTIAL, 7 NOT_MATCH.
- FIFO entry contents: line_data, line base PC (line_pc with its slot bits cleared), start slot.
- State: write pointer, read pointer, occupancy count (0..DEPTH), slot counter for the head entry.
- On push, the slot counter for that entry starts at its start slot.
- Emission: out_valid = count≠0. out_* are decoded combinationally from the head entry at the current slot. out_pc = base | slot.
- On each out handshake:
  - The slot counter advances by 1.
  - If the slot was LINE_INSTRS-1, the head pops and the next entry's start slot loads.
  - If STOP_AT_FLOW=1 and the instruction was JMP or terminal, the head pops immediately.
  - SPLIT never truncates a line.
- line_ready = (count < DEPTH) && !flush && !rst. There is no bypass: a full FIFO refuses a line even if a pop happens in the same cycle.
- Simultaneous push and pop leaves count unchanged; the pointers each advance.
- flush, synchronous:
  - count, pointers and slot counter clear at the next edge.
  - A line offered in the flush cycle is not accepted.
  - The output handshake in the flush cycle is still counted by the consumer but has no internal effect.
- Pointer wrap-around: pointers are log2(DEPTH) bits and wrap naturally.
- PC arithmetic is modulo 2^PC_WIDTH. The slot counter never carries into the base.

## Timing
- Reset state: count=0, pointers=0, slot=0, out_valid=0, line_ready=0 while rst is high and 1 after release. out_pc, out_type, out_data and the flags are 0 while empty.
- Latency: a line accepted at edge t produces out_valid=1 in the cycle after t. Its first instruction is visible that cycle.
- Throughput: one instruction per cycle while out_ready=1 and the FIFO is non-empty. There are no bubbles between lines when the next line is already buffered.
- If rst asserts mid-line, everything clears asynchronously; a partially emitted line is lost.
- out_* must stay stable while out_valid && !out_ready.

## Test plan
- Reset release, then one line {MATCH 'a', MATCH 'b', JMP 0, ACCEPT} at line_pc=0x10 with out_ready=1:
  - Expect 4 outputs at PCs 0x10–0x13 on consecutive cycles starting 1 cycle after acceptance.
  - JMP flags out_is_branch; ACCEPT flags out_is_terminal.
  - Run with STOP_AT_FLOW=0.
- Same line with STOP_AT_FLOW=1: expect exactly 3 outputs (0x10, 0x11, 0x12); the line then pops and out_valid falls to 0.
- line_pc=0x0E, LINE_INSTRS=4: expect outputs only for slots 2 and 3 (PCs 0x0E, 0x0F), then empty.
- Fill DEPTH=2 with out_ready=0:
  - Expect line_ready=0 after 2 pushes.
  - A third line held valid is accepted only on the cycle after the first line's last slot pops.
  - out_* stay stable throughout the stall.
- Flush with 2 lines buffered while a new line is offered:
  - Next cycle: out_valid=0, count=0.
  - The offered line is not accepted; line_ready returns to 1.
- TYPE_WIDTH=4, opcode 9: out_illegal=1, out_is_branch=0, out_is_terminal=0. Also assert rst mid-line and expect out_valid=0 immediately.
